// File: rtl/seven_segment_scan_n.sv
// Time-multiplexed driver for DIGITS common-anode seven-segment digits.
// A free-running prescaler sets the slot length. Inputs are captured once per
// frame, so every digit of a frame comes from the same sample. Optional
// leading-zero blanking and 16-level PWM brightness are included.
//
// state (idx) | meaning
// ------------+-----------------------------------------------
// 0           | rightmost digit slot; the new frame snapshot is taken here
// 1..DIGITS-1 | digit slots in increasing significance
// reset value | DIGITS-1, so the first tick wraps into digit 0
module seven_segment_scan_n #(
    parameter int DIGITS = 4,
    parameter int DIV_W  = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_en,
    input  logic [3:0]            brightness,
    output logic [DIGITS-1:0]     DIGIT,
    output logic [6:0]            DISPLAY,
    output logic                  DP
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]    cnt;
    logic [DIV_W-1:0]    cnt_nxt;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_nxt;
    logic                tick;
    logic                wrap;
    logic                active;

    logic [4*DIGITS-1:0] snap_bcd;
    logic [DIGITS-1:0]   snap_dp;
    logic                snap_lz;

    logic [4*DIGITS-1:0] frm_bcd;
    logic [DIGITS-1:0]   frm_dp;
    logic                frm_lz;

    logic [3:0]          dv [DIGITS];
    logic [DIGITS-1:0]   zrun;
    logic [DIGITS-1:0]   sel_nxt;
    logic [3:0]          v_sel;
    logic                blank_sel;
    logic                dp_sel;
    logic                pwm_on;

    // Seven-segment decode, {a..g}, active-low; 10 is a dash, 11..15 are blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'd10:   s = 7'b1111110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign cnt_nxt = cnt + DIV_W'(1);
    assign tick    = &cnt;
    assign wrap    = tick && (idx == IW'(DIGITS - 1));
    assign idx_nxt = tick ? (wrap ? '0 : idx + IW'(1)) : idx;

    // On the wrap tick, digit 0 is built from the live inputs being captured.
    assign frm_bcd = wrap ? bcd_in : snap_bcd;
    assign frm_dp  = wrap ? dp_in  : snap_dp;
    assign frm_lz  = wrap ? lz_en  : snap_lz;

    // Brightness is compared against the slot phase the next cycle will have.
    assign pwm_on = (brightness == 4'hF) || (cnt_nxt[DIV_W-1 -: 4] < brightness);

    // Selects the digit value, blanking state and decimal point for the next slot.
    always_comb begin
        zrun      = '0;
        sel_nxt   = '0;
        v_sel     = 4'h0;
        blank_sel = 1'b0;
        dp_sel    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            dv[k] = frm_bcd[4*k +: 4];
        end
        zrun[DIGITS-1] = (dv[DIGITS-1] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zrun[k] = (dv[k] == 4'h0) && zrun[k+1];
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                sel_nxt[k] = 1'b1;
                v_sel      = dv[k];
                blank_sel  = frm_lz && (k != 0) && zrun[k];
                dp_sel     = frm_dp[k];
            end
        end
    end

    // Prescaler, slot index and the per-frame input snapshot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt      <= '0;
            idx      <= IW'(DIGITS - 1);
            snap_bcd <= '0;
            snap_dp  <= '0;
            snap_lz  <= 1'b0;
            active   <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
            if (tick) begin
                active <= 1'b1;
            end
            if (wrap) begin
                snap_bcd <= bcd_in;
                snap_dp  <= dp_in;
                snap_lz  <= lz_en;
            end
        end
    end

    // Pin registers: segments load per slot, the digit enable is re-gated every cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            DIGIT   <= '1;
            DISPLAY <= 7'h7F;
            DP      <= 1'b1;
        end else begin
            if (tick) begin
                DISPLAY <= blank_sel ? 7'h7F : seg_decode(v_sel);
                DP      <= ~dp_sel;
            end
            DIGIT <= ((active || tick) && pwm_on) ? ~sel_nxt : '1;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan_n.sv
// Scoreboard bench for seven_segment_scan_n with DIGITS=4, DIV_W=4 (16-cycle slots).
module tb_seven_segment_scan_n;

    logic        clk;
    logic        reset;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lz_en;
    logic [3:0]  brightness;
    logic [3:0]  DIGIT;
    logic [6:0]  DISPLAY;
    logic        DP;

    int n_chk;
    int n_err;

    typedef struct packed {
        logic [3:0] dig;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t sb[$];

    seven_segment_scan_n #(.DIGITS(4), .DIV_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_en      (lz_en),
        .brightness (brightness),
        .DIGIT      (DIGIT),
        .DISPLAY    (DISPLAY),
        .DP         (DP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected segment patterns, {a..g}, active-low.
    function automatic logic [6:0] seg_ref(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111,
              7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        return t[v];
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Push the four slot expectations for a frame captured from these inputs.
    task automatic push_frame(input logic [15:0] b, input logic [3:0] d, input logic lz);
        exp_t e;
        logic allz;
        logic [3:0] v;
        for (int k = 0; k < 4; k++) begin
            allz = 1'b1;
            for (int j = k; j < 4; j++) begin
                v = b[4*j +: 4];
                if (v != 4'h0) allz = 1'b0;
            end
            v     = b[4*k +: 4];
            e.dig = ~(4'd1 << k);
            e.seg = (lz && k > 0 && allz) ? 7'h7F : seg_ref(v);
            e.dp  = ~d[k];
            sb.push_back(e);
        end
    endtask

    task automatic drive(input logic [15:0] b, input logic [3:0] d, input logic lz);
        bcd_in = b;
        dp_in  = d;
        lz_en  = lz;
        push_frame(b, d, lz);
    endtask

    // Called at cnt==0 of a slot: compare against the oldest expectation, then move one slot on.
    task automatic slot();
        exp_t e;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check_val("slot_digit", 32'(DIGIT), 32'(e.dig));
            check_val("slot_seg", 32'(DISPLAY), 32'(e.seg));
            check_val("slot_dp", 32'(DP), 32'(e.dp));
        end
        repeat (16) step();
    endtask

    // One frame of four slots; new stimulus goes in at the start of slot chg_at.
    task automatic run_frame(input int chg_at, input logic [15:0] b, input logic [3:0] d, input logic lz);
        for (int i = 0; i < 4; i++) begin
            if (i == chg_at) drive(b, d, lz);
            slot();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lows;
        n_chk = 0;
        n_err = 0;
        reset = 1'b0;
        brightness = 4'hF;
        drive(16'h1234, 4'b0000, 1'b0);

        // Reset held for three cycles.
        repeat (3) step();
        check_val("rst_digit", 32'(DIGIT), 32'hF);
        check_val("rst_seg", 32'(DISPLAY), 32'h7F);
        check_val("rst_dp", 32'(DP), 32'h1);
        reset = 1'b1;

        // Nothing lights before the first tick.
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (DIGIT !== 4'hF || DISPLAY !== 7'h7F || DP !== 1'b1) bad++;
        end
        check_val("pre_frame_dark", 32'(bad), 32'd0);
        step();

        // Plain scan, then leading-zero cases, then tearing check, then dash/blank/dp.
        run_frame(3, 16'h0070, 4'b0000, 1'b1);
        run_frame(3, 16'h0000, 4'b0000, 1'b1);
        run_frame(3, 16'h1111, 4'b0000, 1'b0);
        run_frame(1, 16'h2222, 4'b0000, 1'b0);
        run_frame(3, 16'hAFB5, 4'b0100, 1'b0);
        run_frame(-1, 16'h0000, 4'b0000, 1'b0);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        // Brightness 4: digit 1 lit exactly during cnt 0..3 of its slot.
        brightness = 4'd4;
        repeat (16) step();
        bad  = 0;
        lows = 0;
        for (int j = 0; j < 16; j++) begin
            if (DIGIT == 4'b1101) lows++;
            if (DIGIT !== ((j < 4) ? 4'b1101 : 4'b1111)) bad++;
            step();
        end
        check_val("pwm4_low_cycles", 32'(lows), 32'd4);
        check_val("pwm4_pattern", 32'(bad), 32'd0);

        // Brightness 0: fully dark, across a frame boundary.
        brightness = 4'd0;
        step();
        bad = 0;
        for (int j = 0; j < 32; j++) begin
            if (DIGIT !== 4'b1111) bad++;
            step();
        end
        check_val("pwm0_dark", 32'(bad), 32'd0);

        // Mid-slot reset returns the pins to their reset values on the next cycle.
        brightness = 4'hF;
        repeat (5) step();
        check_val("pre_rst_lit", 32'(DIGIT != 4'hF), 32'd1);
        reset = 1'b0;
        step();
        check_val("midrst_digit", 32'(DIGIT), 32'hF);
        check_val("midrst_seg", 32'(DISPLAY), 32'h7F);
        check_val("midrst_dp", 32'(DP), 32'h1);
        reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
